// File: rtl/bist_resp_analyzer.sv
// ---------------------------------------------------------------------------
// bist_resp_analyzer
//
// This is the response-analysis stage of the PMBIST datapath. It sits right
// after the registered read-data pipeline. Each cycle it may take one memory
// read beat (address, data read, expected data) and compare the data read
// against the expected value. Over a march pass it records:
//   - a sticky fail flag,
//   - a saturating count of mismatching beats,
//   - the address and XOR syndrome of the first mismatching beat.
// When the final beat has been processed it reports done to the BIST
// controller.
//
// Optional feature macro: PMBIST_MISR_EN
//   When defined, the block adds a multiple-input signature register
//   (MISR) that compresses every accepted rd_data beat. The register is
//   exposed on the misr_sig port and uses the MISR_POLY parameter. When the
//   macro is not defined, the block has no misr_sig port, no MISR_POLY
//   parameter and no MISR logic.
//
// Parameters:
//   DATA_W     read/expected data width
//   ADDR_W     memory address width
//   CNT_W      fail counter width; the counter saturates at all-ones
//   MISR_POLY  MISR feedback polynomial (only with PMBIST_MISR_EN)
//
// Ports:
//   clk              sole clock, rising edge
//   rst              asynchronous, active-low reset
//   start            pulse: clear the statistics and begin a pass
//   rd_valid         a read beat is present this cycle
//   rd_last          this beat is the final beat of the pass (needs rd_valid)
//   rd_addr          address of the beat
//   rd_data          data read from memory
//   exp_data         expected data for the beat
//   busy             high while a pass is running
//   done             high once the pass has finished
//   fail             sticky: at least one mismatch in this pass
//   fail_cnt         number of mismatching beats (saturating)
//   first_fail_addr  address of the first mismatch
//   first_fail_syn   rd_data ^ exp_data of the first mismatch
//   misr_sig         signature of the accepted beats (PMBIST_MISR_EN only)
// ---------------------------------------------------------------------------
module bist_resp_analyzer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
`ifdef PMBIST_MISR_EN
  ,
  parameter logic [DATA_W-1:0] MISR_POLY = 8'h1D
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rd_valid,
  input  logic              rd_last,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_syn
`ifdef PMBIST_MISR_EN
  ,
  output logic [DATA_W-1:0] misr_sig
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              accept;
  logic              clear;
  logic              mismatch;
  logic [DATA_W-1:0] syndrome;
  logic              cnt_full;

  // A beat counts only while a pass is running. start is honoured only
  // outside RUN. Because IDLE and DONE never accept beats, "start wins over
  // rd_valid" follows directly from this split.
  assign accept   = (state_q == RUN) && rd_valid;
  assign clear    = (state_q != RUN) && start;
  assign syndrome = rd_data ^ exp_data;
  assign mismatch = (syndrome != '0);
  assign cnt_full = (fail_cnt == {CNT_W{1'b1}});

  // State register. An asynchronous reset drops any pass that is in
  // progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The last beat moves RUN to DONE on the same edge
  // that folds the beat into the statistics. As a result, done rises in
  // the same cycle as the final counts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (rd_valid && rd_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Failure statistics. The first-failure capture is gated by the
  // previous value of fail, so later mismatches never overwrite the first
  // address and syndrome. The counter holds once it reaches all-ones
  // instead of wrapping to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_syn  <= '0;
    end else if (clear) begin
      fail            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_syn  <= '0;
    end else if (accept && mismatch) begin
      fail <= 1'b1;
      if (!cnt_full) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end
      if (!fail) begin
        first_fail_addr <= rd_addr;
        first_fail_syn  <= syndrome;
      end
    end
  end

`ifdef PMBIST_MISR_EN
  logic [DATA_W-1:0] misr_next;

  // Galois-style MISR step. Shift left by one bit. If the bit shifted out
  // was 1, fold the polynomial back in. Then mix in the incoming read data.
  always_comb begin
    misr_next = {misr_sig[DATA_W-2:0], 1'b0} ^ rd_data;
    if (misr_sig[DATA_W-1]) begin
      misr_next = misr_next ^ MISR_POLY;
    end
  end

  // The signature register is cleared on start (like the statistics) and
  // advances only on accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misr_sig <= '0;
    end else if (clear) begin
      misr_sig <= '0;
    end else if (accept) begin
      misr_sig <= misr_next;
    end
  end
`endif

endmodule
